// File: rtl/mips_data_mem_responder_if.sv
// Data-port bus between the core (master) and the data memory responder (slave).
// Byte lanes are ordered big-endian: lane [0] carries the byte at addr+0.
interface mips_data_mem_responder_if;
    logic            mem_req;
    logic            mem_write_en;
    logic [31:0]     mem_addr;
    logic [0:3][7:0] mem_data_in;
    logic [0:3][7:0] mem_data_out;
    logic            mem_ready;
    logic            mem_err;
    logic            mem_busy;

    modport master (
        output mem_req, mem_write_en, mem_addr, mem_data_in,
        input  mem_data_out, mem_ready, mem_err, mem_busy
    );

    modport slave (
        input  mem_req, mem_write_en, mem_addr, mem_data_in,
        output mem_data_out, mem_ready, mem_err, mem_busy
    );
endinterface

// File: rtl/mips_data_mem_responder.sv
// Word-addressed, big-endian data memory with a req/ready handshake and a fixed
// number of wait states between accepting a request and its one-cycle response.
module mips_data_mem_responder #(
    parameter int          ADDR_BITS   = 12,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 2
) (
    input  logic                        clk,
    input  logic                        rst_b,
    mips_data_mem_responder_if.slave    bus
);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

    localparam int          DEPTH    = 1 << ADDR_BITS;
    localparam logic [32:0] SPAN     = 33'd1 << ADDR_BITS;
    localparam logic [3:0]  CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [31:0]     addr_q;
    logic [0:3][7:0] data_q;
    logic            we_q;
    logic            err_q;
    logic [0:3][7:0] dout_q;
    logic [7:0]      mem_q [DEPTH];

    logic            accept;
    logic            enter_resp;
    logic [31:0]     req_addr;
    logic [0:3][7:0] req_data;
    logic            req_we;
    logic            req_err;
    logic [ADDR_BITS-1:0] off0, off1, off2, off3;

    function automatic logic addr_err(input logic [31:0] a);
        logic [32:0] last_byte;
        last_byte = {1'b0, a - BASE_ADDR} + 33'd3;
        return (a[1:0] != 2'b00) || (a < BASE_ADDR) || (last_byte >= SPAN);
    endfunction

    assign accept = bus.mem_req && ((state_q == S_IDLE) || (state_q == S_RESP));

    // With no wait states the accepting edge is also the committing edge, so the
    // live bus values are used instead of the (not yet loaded) capture registers.
    assign enter_resp = (WAIT_CYCLES == 0) ? accept
                                           : ((state_q == S_WAIT) && (cnt_q == 4'd0));
    assign req_addr   = (WAIT_CYCLES == 0) ? bus.mem_addr     : addr_q;
    assign req_data   = (WAIT_CYCLES == 0) ? bus.mem_data_in  : data_q;
    assign req_we     = (WAIT_CYCLES == 0) ? bus.mem_write_en : we_q;
    assign req_err    = addr_err(req_addr);

    assign off0 = ADDR_BITS'(req_addr - BASE_ADDR);
    assign off1 = off0 + ADDR_BITS'(1);
    assign off2 = off0 + ADDR_BITS'(2);
    assign off3 = off0 + ADDR_BITS'(3);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        case (state_q)
            S_IDLE, S_RESP: begin
                if (bus.mem_req) begin
                    state_d = (WAIT_CYCLES == 0) ? S_RESP : S_WAIT;
                    cnt_d   = CNT_LOAD;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == 4'd0) state_d = S_RESP;
                else               cnt_d   = cnt_q - 4'd1;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        bus.mem_ready    = (state_q == S_RESP);
        bus.mem_err      = (state_q == S_RESP) && err_q;
        bus.mem_busy     = (state_q != S_IDLE);
        bus.mem_data_out = dout_q;
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            addr_q <= bus.mem_addr;
            data_q <= bus.mem_data_in;
            we_q   <= bus.mem_write_en;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_b) begin
            err_q  <= 1'b0;
            dout_q <= '0;
        end else if (enter_resp) begin
            err_q <= req_err;
            if (!req_err && !req_we)
                dout_q <= {mem_q[off0], mem_q[off1], mem_q[off2], mem_q[off3]};
        end
    end

    // Storage is never cleared; reset only suppresses a write that has not committed.
    always_ff @(posedge clk) begin
        if (!rst_b && enter_resp && req_we && !req_err) begin
            mem_q[off0] <= req_data[0];
            mem_q[off1] <= req_data[1];
            mem_q[off2] <= req_data[2];
            mem_q[off3] <= req_data[3];
        end
    end

endmodule

// File: tb/tb_mips_data_mem_responder.sv
// Four responder instances (different wait states / base addresses) driven by
// directed scenarios plus random traffic checked against an associative-array model.
module tb_mips_data_mem_responder;

    localparam int AB = 12;

    logic        clk = 1'b0;
    logic [3:0]  rst = 4'b0000;
    logic [3:0]  req = 4'b0000;
    logic [3:0]  we  = 4'b0000;
    logic [31:0] addr [4];
    logic [31:0] din  [4];
    logic [31:0] dout [4];
    logic [3:0]  rdy, err, busy;

    int vec  = 0;
    int miss = 0;

    always #5 clk = ~clk;

    function automatic int w_of(input int d);
        return (d == 0) ? 2 : (d == 1) ? 0 : (d == 2) ? 2 : 1;
    endfunction

    function automatic logic [31:0] base_of(input int d);
        return (d == 2) ? 32'h0000_1000 : 32'h0000_0000;
    endfunction

    genvar g;
    generate
        for (g = 0; g < 4; g++) begin : gd
            mips_data_mem_responder_if bus ();
            assign bus.mem_req      = req[g];
            assign bus.mem_write_en = we[g];
            assign bus.mem_addr     = addr[g];
            assign bus.mem_data_in  = din[g];
            assign dout[g]          = bus.mem_data_out;
            assign rdy[g]           = bus.mem_ready;
            assign err[g]           = bus.mem_err;
            assign busy[g]          = bus.mem_busy;
            mips_data_mem_responder #(
                .ADDR_BITS   (AB),
                .BASE_ADDR   ((g == 2) ? 32'h0000_1000 : 32'h0000_0000),
                .WAIT_CYCLES ((g == 0) ? 2 : (g == 1) ? 0 : (g == 2) ? 2 : 1)
            ) dut (
                .clk   (clk),
                .rst_b (rst[g]),
                .bus   (bus.slave)
            );
        end
    endgenerate

    // Issue one request, then scramble the bus so only captured values can matter.
    task automatic do_req(input int d, input logic w, input logic [31:0] a,
                          input logic [31:0] dat, output int lat, output logic e,
                          output logic [31:0] q);
        @(negedge clk);
        req[d] = 1'b1; we[d] = w; addr[d] = a; din[d] = dat;
        @(posedge clk);
        #1;
        req[d] = 1'b0; we[d] = $urandom_range(0, 1); addr[d] = $urandom; din[d] = $urandom;
        lat = 1; e = 1'b0; q = '0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (rdy[d]) begin
                e = err[d];
                q = dout[d];
                return;
            end
            lat++;
            @(posedge clk);
        end
        lat = -1;
    endtask

    task automatic test_reset();
        for (int d = 0; d < 4; d++) begin
            addr[d] = '0; din[d] = '0;
        end
        rst = 4'b1111;
        repeat (3) @(posedge clk);
        #1 rst = 4'b0000;
        @(negedge clk);
        for (int d = 0; d < 4; d++) begin
            vec++;
            if ({rdy[d], err[d], busy[d], dout[d]} !== 35'b0) begin
                miss++;
                $display("FAIL reset_state dut%0d: rdy=%b err=%b busy=%b dout=%h, want all zero",
                         d, rdy[d], err[d], busy[d], dout[d]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] mdl [int];
        logic [31:0] written [$];
        logic [31:0] last, a, dat, q, base, exp_q;
        logic        w, e, exp_e;
        int          lat, k;
        for (int d = 0; d < 4; d++) begin
            base = base_of(d);
            last = '0;
            written.delete();
            mdl.delete();
            for (int n = 0; n < 30; n++) begin
                k = $urandom_range(0, 3);
                dat = $urandom;
                if (k == 0 || written.size() == 0) begin
                    w = 1'b1; a = base + 32'(4 * $urandom_range(0, 15));
                end else if (k < 3) begin
                    w = 1'b0; a = written[$urandom_range(0, written.size() - 1)];
                end else begin
                    w = $urandom_range(0, 1);
                    case ($urandom_range(0, 3))
                        0:       a = base + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(1, 3));
                        1:       a = base - 32'd4;
                        2:       a = base + 32'(1 << AB);
                        default: a = 32'hFFFF_FFFC;
                    endcase
                end
                exp_e = (a[1:0] != 2'b00) || (a < base) ||
                        ((longint'(a - base) + 64'd3) >= (64'd1 << AB));
                exp_q = last;
                if (!exp_e && !w) begin
                    exp_q = mdl[a];
                    last  = exp_q;
                end
                if (!exp_e && w) begin
                    if (!mdl.exists(a)) written.push_back(a);
                    mdl[a] = dat;
                end
                do_req(d, w, a, dat, lat, e, q);
                vec++;
                if (lat != w_of(d) + 1) begin
                    miss++;
                    $display("FAIL rand_latency dut%0d addr=%h: got %0d want %0d", d, a, lat, w_of(d) + 1);
                end
                vec++;
                if (e !== exp_e) begin
                    miss++;
                    $display("FAIL rand_err dut%0d addr=%h we=%b: got %b want %b", d, a, w, e, exp_e);
                end
                vec++;
                if (q !== exp_q) begin
                    miss++;
                    $display("FAIL rand_data dut%0d addr=%h we=%b: got %h want %h", d, a, w, q, exp_q);
                end
                @(negedge clk);
                vec++;
                if (rdy[d] !== 1'b0 || err[d] !== 1'b0) begin
                    miss++;
                    $display("FAIL rand_pulse dut%0d: ready=%b err=%b after response, want 0 0", d, rdy[d], err[d]);
                end
            end
        end
    endtask

    task automatic test_write_read();
        int lat; logic e; logic [31:0] q;
        do_req(0, 1'b1, 32'h10, 32'h1234_5678, lat, e, q);
        vec++;
        if (lat != 3 || e !== 1'b0) begin
            miss++;
            $display("FAIL wr_basic: lat=%0d err=%b, want 3 0", lat, e);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, lat, e, q);
        vec++;
        if (lat != 3 || e !== 1'b0 || q !== 32'h1234_5678) begin
            miss++;
            $display("FAIL rd_basic: lat=%0d err=%b data=%h, want 3 0 12345678", lat, e, q);
        end
    endtask

    task automatic test_zero_wait_stream();
        logic [31:0] wd [3];
        int lat; logic e; logic [31:0] q;
        for (int i = 0; i < 3; i++) begin
            wd[i] = $urandom;
            do_req(1, 1'b1, 32'(4 * i), wd[i], lat, e, q);
            vec++;
            if (lat != 1 || e !== 1'b0) begin
                miss++;
                $display("FAIL w0_write%0d: lat=%0d err=%b, want 1 0", i, lat, e);
            end
        end
        @(negedge clk);
        req[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            if (i < 2) addr[1] = 32'(4 * (i + 1));
            else       req[1]  = 1'b0;
            @(negedge clk);
            vec++;
            if (rdy[1] !== 1'b1 || err[1] !== 1'b0 || dout[1] !== wd[i]) begin
                miss++;
                $display("FAIL w0_stream%0d: ready=%b err=%b data=%h, want 1 0 %h", i, rdy[1], err[1], dout[1], wd[i]);
            end
        end
        @(negedge clk);
        vec++;
        if (rdy[1] !== 1'b0 || busy[1] !== 1'b0) begin
            miss++;
            $display("FAIL w0_stream_end: ready=%b busy=%b, want 0 0", rdy[1], busy[1]);
        end
    endtask

    task automatic test_misaligned();
        int lat; logic e; logic [31:0] q;
        do_req(0, 1'b1, 32'h11, 32'hDEAD_BEEF, lat, e, q);
        vec++;
        if (lat != 3 || e !== 1'b1 || q !== 32'h1234_5678) begin
            miss++;
            $display("FAIL misaligned_wr: lat=%0d err=%b data=%h, want 3 1 12345678", lat, e, q);
        end
        do_req(0, 1'b0, 32'h10, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b0 || q !== 32'h1234_5678) begin
            miss++;
            $display("FAIL misaligned_after: err=%b data=%h, want 0 12345678", e, q);
        end
    endtask

    task automatic test_range();
        int lat; logic e; logic [31:0] q;
        do_req(2, 1'b1, 32'h1FFC, 32'h0BAD_F00D, lat, e, q);
        do_req(2, 1'b0, 32'h1FFC, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b0 || q !== 32'h0BAD_F00D) begin
            miss++;
            $display("FAIL range_top: err=%b data=%h, want 0 0badf00d", e, q);
        end
        do_req(2, 1'b0, 32'h0FFC, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b1 || q !== 32'h0BAD_F00D) begin
            miss++;
            $display("FAIL range_below: err=%b data=%h, want 1 0badf00d", e, q);
        end
        do_req(2, 1'b0, 32'h2000, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b1 || q !== 32'h0BAD_F00D) begin
            miss++;
            $display("FAIL range_above: err=%b data=%h, want 1 0badf00d", e, q);
        end
        do_req(2, 1'b1, 32'h1FFE, 32'h1111_1111, lat, e, q);
        do_req(2, 1'b0, 32'h1FFC, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b0 || q !== 32'h0BAD_F00D) begin
            miss++;
            $display("FAIL range_misaligned_top: err=%b data=%h, want 0 0badf00d", e, q);
        end
    endtask

    task automatic test_reset_abort();
        int lat, pulses; logic e; logic [31:0] q;
        do_req(0, 1'b1, 32'h20, 32'h1122_3344, lat, e, q);
        @(negedge clk);
        req[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h20; din[0] = 32'hCAFE_F00D;
        @(posedge clk);
        #1 req[0] = 1'b0;
        @(negedge clk);
        vec++;
        if (busy[0] !== 1'b1) begin
            miss++;
            $display("FAIL abort_busy_wait: busy=%b, want 1", busy[0]);
        end
        rst[0] = 1'b1;
        @(posedge clk);
        #1 rst[0] = 1'b0;
        @(negedge clk);
        vec++;
        if (busy[0] !== 1'b0 || rdy[0] !== 1'b0 || dout[0] !== 32'h0) begin
            miss++;
            $display("FAIL abort_state: busy=%b ready=%b data=%h, want 0 0 0", busy[0], rdy[0], dout[0]);
        end
        pulses = 0;
        repeat (5) begin
            @(negedge clk);
            if (rdy[0]) pulses++;
        end
        vec++;
        if (pulses != 0) begin
            miss++;
            $display("FAIL abort_no_ready: pulses=%0d, want 0", pulses);
        end
        do_req(0, 1'b0, 32'h20, 32'h0, lat, e, q);
        vec++;
        if (e !== 1'b0 || q !== 32'h1122_3344) begin
            miss++;
            $display("FAIL abort_discard: err=%b data=%h, want 0 11223344", e, q);
        end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        req[3] = 1'b1; we[3] = 1'b1; addr[3] = 32'h40; din[3] = 32'hA5A5_A5A5;
        @(posedge clk);
        #1 we[3] = 1'b0; din[3] = 32'h0;
        @(posedge clk);
        @(negedge clk);
        vec++;
        if (rdy[3] !== 1'b1 || err[3] !== 1'b0) begin
            miss++;
            $display("FAIL b2b_first: ready=%b err=%b, want 1 0", rdy[3], err[3]);
        end
        @(posedge clk);
        #1 req[3] = 1'b0;
        @(negedge clk);
        vec++;
        if (rdy[3] !== 1'b0 || busy[3] !== 1'b1) begin
            miss++;
            $display("FAIL b2b_gap: ready=%b busy=%b, want 0 1", rdy[3], busy[3]);
        end
        @(negedge clk);
        vec++;
        if (rdy[3] !== 1'b1 || err[3] !== 1'b0 || dout[3] !== 32'hA5A5_A5A5) begin
            miss++;
            $display("FAIL b2b_second: ready=%b err=%b data=%h, want 1 0 a5a5a5a5", rdy[3], err[3], dout[3]);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_random();
        test_write_read();
        test_zero_wait_stream();
        test_misaligned();
        test_range();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
